// File: rtl/frame_sequencer.sv
// frame_sequencer -- per-frame scheduler for the brick-game datapath.
//
// Generates a periodic one-cycle frame-start pulse, then serves N_CH object
// channels in fixed order (wait for frame_term, request, wait for ack), and
// signals end of frame. Tracks overruns (a tick while a frame is still in
// progress), counts skipped ticks, and optionally abandons a stuck channel.
//
// Optional feature macro: FRAME_SEQ_TIMEOUT_EN
//   defined   -> per-channel wait counter; after TIMEOUT cycles in
//                WAIT_TERM+REQ the channel is flagged and skipped.
//   undefined -> no wait counter, o_timeout tied to 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_enable          period counter runs while high
//   i_clr             clears o_overrun / o_skip_cnt / o_timeout
//   o_cal_frame       one-cycle frame-start pulse
//   i_frame_term[ch]  channel finished computing this frame
//   o_req[ch]         one-hot data request
//   i_ack[ch]         channel data-valid pulse
//   o_ch_idx          channel currently served
//   o_frame_done      one-cycle pulse, all channels served
//   o_frame_cnt       completed frames (wraps)
//   o_overrun         sticky, tick arrived while busy
//   o_skip_cnt        skipped ticks (saturates at 255)
//   o_timeout[ch]     sticky per-channel timeout flags
module frame_sequencer #(
  parameter int N_CH         = 2,
  parameter int FRAME_PERIOD = 300,
  parameter int TIMEOUT      = 255
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_enable,
  input  logic                                     i_clr,
  output logic                                     o_cal_frame,
  input  logic [N_CH-1:0]                          i_frame_term,
  output logic [N_CH-1:0]                          o_req,
  input  logic [N_CH-1:0]                          i_ack,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_ch_idx,
  output logic                                     o_frame_done,
  output logic [15:0]                              o_frame_cnt,
  output logic                                     o_overrun,
  output logic [7:0]                               o_skip_cnt,
  output logic [N_CH-1:0]                          o_timeout
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int P_W  = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [P_W-1:0]  P_LAST  = P_W'(FRAME_PERIOD - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [P_W-1:0]  p_q;
  logic [1:0]      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [N_CH-1:0] req_q, req_d;
  logic            cal_q, cal_d;
  logic            done_q, done_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ovr_q, ovr_d;
  logic [7:0]      skip_q, skip_d;

  logic tick;
  logic busy;
  logic ovr_set;
  logic to_hit;
  logic advance;

  assign tick    = i_enable && (p_q == P_LAST);
  assign busy    = (state_q == S_WAIT) || (state_q == S_REQ);
  // A tick that lands mid-frame is dropped rather than restarting the frame.
  assign ovr_set = tick && busy;

  // ---- period counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else if (i_enable) begin
      p_q <= (p_q == P_LAST) ? '0 : p_q + P_W'(1);
    end
  end

  // ---- channel wait watchdog ----
`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int W_W = $clog2(TIMEOUT + 1);
  localparam logic [W_W-1:0] W_LAST = W_W'(TIMEOUT - 1);

  logic [W_W-1:0]  wait_q, wait_d;
  logic [N_CH-1:0] to_q, to_d;
  logic            to_set;
  logic            wait_clr;

  assign to_hit   = busy && (wait_q == W_LAST);
  // An ack arriving on the very last allowed cycle still counts as served.
  assign to_set   = to_hit && ((state_q == S_WAIT) || !i_ack[ch_q]);
  // Entering WAIT_TERM: either from another state or moving to a new channel.
  assign wait_clr = (state_d == S_WAIT) && ((state_q != S_WAIT) || (ch_d != ch_q));

  always_comb begin
    wait_d = wait_q;
    if (wait_clr) begin
      wait_d = '0;
    end else if (busy) begin
      wait_d = wait_q + W_W'(1);
    end
    to_d = i_clr ? '0 : to_q;
    if (to_set) begin
      to_d[ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      to_q   <= '0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end

  assign o_timeout = to_q;
`else
  assign to_hit    = 1'b0;
  assign o_timeout = '0;
`endif

  // ---- frame FSM next state ----
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    req_d   = req_q;
    cal_d   = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          cal_d   = 1'b1;
          ch_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (to_hit) begin
          advance = 1'b1;
        end else if (!cal_q && i_frame_term[ch_q]) begin
          // Term is ignored during the cal pulse so last frame's term is not reused.
          req_d   = N_CH'(1) << ch_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i_ack[ch_q] || to_hit) begin
          req_d   = '0;
          advance = 1'b1;
        end
      end
      S_DONE: begin
        if (tick) begin
          cal_d   = 1'b1;
          ch_d    = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (ch_q == CH_LAST) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 16'd1;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        state_d = S_WAIT;
      end
    end
  end

  // Status: a new set in the same cycle as i_clr wins.
  always_comb begin
    ovr_d  = ovr_set | (ovr_q & ~i_clr);
    skip_d = i_clr ? 8'd0 : skip_q;
    if (ovr_set) begin
      skip_d = sat_inc8(skip_d);
    end
  end

  // ---- registered state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      req_q   <= '0;
      cal_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      req_q   <= req_d;
      cal_q   <= cal_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      skip_q  <= skip_d;
    end
  end

  assign o_cal_frame  = cal_q;
  assign o_req        = req_q;
  assign o_ch_idx     = ch_q;
  assign o_frame_done = done_q;
  assign o_frame_cnt  = cnt_q;
  assign o_overrun    = ovr_q;
  assign o_skip_cnt   = skip_q;

endmodule

// File: tb/tb_frame_sequencer.sv
`timescale 1ns/1ps
module tb_frame_sequencer;

  localparam int N_CH = 2;
  localparam int FP   = 10;
  localparam int TO   = 20;
`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_clr = 1'b0;
  logic [1:0]  i_frame_term = 2'b00;
  logic [1:0]  i_ack = 2'b00;
  logic        o_cal_frame;
  logic [1:0]  o_req;
  logic [0:0]  o_ch_idx;
  logic        o_frame_done;
  logic [15:0] o_frame_cnt;
  logic        o_overrun;
  logic [7:0]  o_skip_cnt;
  logic [1:0]  o_timeout;

  frame_sequencer #(.N_CH(N_CH), .FRAME_PERIOD(FP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_clr(i_clr),
    .o_cal_frame(o_cal_frame), .i_frame_term(i_frame_term), .o_req(o_req),
    .i_ack(i_ack), .o_ch_idx(o_ch_idx), .o_frame_done(o_frame_done),
    .o_frame_cnt(o_frame_cnt), .o_overrun(o_overrun), .o_skip_cnt(o_skip_cnt),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit armed  = 0;
  int ack_mode = 0;  // 0: never ack, 1: ack while req visible, 2: ack one cycle after req rises

  // Behavioural model: a frame is "busy" from the cal pulse until the last
  // channel is served; "fin" is the single cycle that reports completion.
  bit          m_busy, m_fin, m_reqing, m_cal, m_done, m_ovr;
  int          m_p, m_ch, m_wait, m_skip;
  int unsigned m_cnt;
  bit [1:0]    m_to;

  always @(posedge clk) begin : model
    bit tick, served, timed, ovr_hit, new_cal, new_done;
    int t_ch;
    if (rst) begin
      m_busy = 0; m_fin = 0; m_reqing = 0; m_cal = 0; m_done = 0; m_ovr = 0;
      m_p = 0; m_ch = 0; m_wait = 0; m_skip = 0; m_cnt = 0; m_to = 2'b00;
      cyc = 0; armed = 1;
    end else begin
      cyc++;
      tick = i_enable && (m_p == FP - 1);
      if (i_enable) m_p = (m_p == FP - 1) ? 0 : m_p + 1;
      served = 0; timed = 0; ovr_hit = 0; new_cal = 0; new_done = 0; t_ch = m_ch;
      if (m_busy && !m_fin) begin
        ovr_hit = tick;
        if (!m_reqing) begin
          if (TO_EN && m_wait == TO - 1) timed = 1;
          else if (!m_cal && i_frame_term[m_ch]) m_reqing = 1;
        end else begin
          if (i_ack[m_ch]) served = 1;
          else if (TO_EN && m_wait == TO - 1) timed = 1;
        end
        if (timed) served = 1;
        m_wait++;
        if (served) begin
          m_reqing = 0;
          m_wait = 0;
          if (m_ch == N_CH - 1) begin
            m_fin = 1; new_done = 1; m_cnt = (m_cnt + 1) % 65536;
          end else begin
            m_ch++;
          end
        end
      end else begin
        m_fin = 0;
        if (tick) begin
          m_busy = 1; m_ch = 0; m_reqing = 0; m_wait = 0; new_cal = 1;
        end else begin
          m_busy = 0;
        end
      end
      m_cal = new_cal;
      m_done = new_done;
      if (i_clr) begin m_ovr = 0; m_skip = 0; m_to = 2'b00; end
      if (ovr_hit) begin m_ovr = 1; if (m_skip < 255) m_skip++; end
      if (timed) m_to[t_ch] = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [31:0] act, exp;
    logic [1:0]  exp_req;
    if (armed) begin
      exp_req = (m_busy && !m_fin && m_reqing) ? (2'b01 << m_ch) : 2'b00;
      exp = {m_cal, exp_req, m_ch[0], m_done, m_cnt[15:0], m_ovr, m_skip[7:0], m_to};
      act = {o_cal_frame, o_req, o_ch_idx, o_frame_done, o_frame_cnt, o_overrun, o_skip_cnt, o_timeout};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model cyc=%0d got cal=%b req=%b ch=%b done=%b cnt=%0d ovr=%b skip=%0d to=%b required cal=%b req=%b ch=%b done=%b cnt=%0d ovr=%b skip=%0d to=%b",
                 cyc, o_cal_frame, o_req, o_ch_idx, o_frame_done, o_frame_cnt, o_overrun, o_skip_cnt, o_timeout,
                 exp[31], exp[30:29], exp[28], exp[27], exp[26:11], exp[10], exp[9:2], exp[1:0]);
      end
    end
  end

  // Channel responder.
  initial begin : responder
    logic [1:0] req_prev;
    req_prev = 2'b00;
    forever begin
      @(negedge clk);
      case (ack_mode)
        1:       i_ack = o_req;
        2:       i_ack = o_req & req_prev;
        default: i_ack = 2'b00;
      endcase
      req_prev = o_req;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (cyc != k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      n_chk++;
      n_fail++;
      $display("FAIL goto cyc=%0d required %0d", cyc, k);
    end
  endtask

  // Leaves the caller at the negedge of cycle 0 (first cycle with rst low).
  task automatic do_reset(input logic [1:0] term, input int amode);
    @(negedge clk);
    rst = 1'b1; i_enable = 1'b1; i_clr = 1'b0; i_frame_term = term; ack_mode = amode;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  localparam int CLR_AT = TO_EN ? 51 : 41;

  initial begin : stim
    // Basic frame, immediate ack.
    do_reset(2'b11, 1);
    chk("rst_cal", o_cal_frame, 0);
    chk("rst_req", o_req, 0);
    chk("rst_cnt", o_frame_cnt, 0);
    chk("rst_status", {o_overrun, o_skip_cnt, o_timeout}, 0);
    goto(10); chk("basic_cal10", o_cal_frame, 1);
    goto(12); chk("basic_req01", o_req, 2'b01);
    goto(14); chk("basic_req10", o_req, 2'b10);
    goto(15); chk("basic_done", o_frame_done, 1);
    goto(20); chk("basic_cal20", o_cal_frame, 1);
    goto(25); chk("basic_cnt2", o_frame_cnt, 2);
    chk("basic_no_ovr", o_overrun, 0);

    // Overrun: channel 1 term held low 15 cycles after first cal.
    do_reset(2'b11, 1);
    goto(10); i_frame_term = 2'b01;
    goto(20); chk("ovr_cal20_suppressed", o_cal_frame, 0);
    chk("ovr_flag", o_overrun, 1);
    chk("ovr_skip", o_skip_cnt, 1);
    goto(25); i_frame_term = 2'b11;
    goto(30); chk("ovr_cal30", o_cal_frame, 1);

    // Timeout: channel 0 term never rises.
    do_reset(2'b10, 1);
    goto(29); chk("to_before", o_timeout, 0);
    goto(30);
    if (TO_EN) begin
      chk("to_flag", o_timeout, 2'b01);
      chk("to_next_ch", o_ch_idx, 1);
      goto(32); chk("to_done", o_frame_done, 1);
    end else begin
      chk("to_off_flag", o_timeout, 0);
      chk("to_off_stuck", o_ch_idx, 0);
      goto(40); chk("to_off_no_done", o_frame_cnt, 0);
    end

    // Enable gating, one-cycle-late ack.
    do_reset(2'b11, 2);
    goto(5);  i_enable = 1'b0;
    goto(12); i_enable = 1'b1;
    goto(16); chk("en_cal16", o_cal_frame, 0);
    goto(17); chk("en_cal17", o_cal_frame, 1);
    goto(19); i_enable = 1'b0;
    goto(24); chk("en_frame_completes", o_frame_done, 1);
    goto(45); chk("en_cnt", o_frame_cnt, 1);
    i_enable = 1'b1;

    // Stale term and mid-operation reset (no acks, request stays up).
    do_reset(2'b11, 0);
    goto(10); chk("stale_req_during_cal", o_req, 0);
    goto(11); chk("stale_req_after_cal", o_req, 0);
    goto(12); chk("stale_req_up", o_req, 2'b01);
    goto(13); rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {o_cal_frame, o_req, o_ch_idx, o_frame_done, o_frame_cnt, o_overrun, o_skip_cnt, o_timeout}, 0);
    rst = 1'b0;
    goto(9);  chk("midrst_cal9", o_cal_frame, 0);
    goto(10); chk("midrst_cal10", o_cal_frame, 1);

    // Clear, then clear coincident with a new overrun.
    do_reset(2'b01, 1);
    goto(CLR_AT);
    chk("clr_pre_ovr", o_overrun, 1);
    chk("clr_pre_skip", o_skip_cnt, 3);
    chk("clr_pre_to", o_timeout, TO_EN ? 2'b10 : 2'b00);
    i_clr = 1'b1;
    goto(CLR_AT + 1); i_clr = 1'b0;
    chk("clr_status", {o_overrun, o_skip_cnt, o_timeout}, 0);
    goto(CLR_AT + 8); i_clr = 1'b1;
    goto(CLR_AT + 9); i_clr = 1'b0;
    chk("clr_set_wins_ovr", o_overrun, 1);
    chk("clr_set_wins_skip", o_skip_cnt, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
